// File: rtl/alarm_pkg.sv
// Shared definitions for the multi-zone alarm controller.
//   state_t    : FSM state encoding
//   SEL_*      : timer load-value select codes
//   zone_delay : extracts one zone's delay field from the packed delay bus
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_DISARMED   = 3'd0,
    ST_WAIT_OPEN  = 3'd1,
    ST_WAIT_CLOSE = 3'd2,
    ST_ARMING     = 3'd3,
    ST_ARMED      = 3'd4,
    ST_ENTRY      = 3'd5,
    ST_SOUNDING   = 3'd6,
    ST_HOLD       = 3'd7
  } state_t;

  localparam logic [1:0] SEL_ARM   = 2'd0;
  localparam logic [1:0] SEL_ZONE  = 2'd1;
  localparam logic [1:0] SEL_ALARM = 2'd2;

  // Upper bounds for the generic extractor; N_ZONES*TW must fit in ZBUS_W
  // and TW must not exceed DLY_W.
  localparam int ZBUS_W = 256;
  localparam int DLY_W  = 16;

  // Field idx of width tw from a packed bus, zero-extended to DLY_W.
  function automatic logic [DLY_W-1:0] zone_delay(input logic [ZBUS_W-1:0] bus,
                                                  input int idx, input int tw);
    logic [ZBUS_W-1:0] s;
    logic [DLY_W-1:0]  mask;
    s    = bus >> (idx * tw);
    mask = (DLY_W'(1) << tw) - DLY_W'(1);
    return s[DLY_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/alarm_timer.sv
// Down-counter with prescaler shared by the arm, entry and siren-hold delays.
//   clock, reset : clock / async active-low reset
//   clear        : abandon any count in progress
//   load, value  : start a count of max(value,1) ticks (prescaler restarts)
//   expired      : high in the cycle before the final tick edge, so the
//                  consumer changes state exactly on that edge
module alarm_timer #(
  parameter int TW       = 4,
  parameter int PRESCALE = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          load,
  input  logic [TW-1:0] value,
  output logic          expired
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [TW-1:0] r_cnt;
  logic [PW-1:0] r_pre;
  logic          w_tick;

  assign w_tick  = (r_pre == PW'(PRESCALE - 1));
  // r_cnt==0 means idle, so a finished count cannot re-fire.
  assign expired = (r_cnt == TW'(1)) && w_tick;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_pre <= '0;
    end else if (load) begin
      r_cnt <= (value == '0) ? TW'(1) : value;
      r_pre <= '0;
    end else if (clear) begin
      r_cnt <= '0;
      r_pre <= '0;
    end else if (r_cnt != '0) begin
      r_pre <= w_tick ? '0 : r_pre + PW'(1);
      if (w_tick) r_cnt <= r_cnt - TW'(1);
    end
  end

endmodule

// File: rtl/alarm_controller_nz.sv
// Multi-zone anti-theft alarm with fuel-pump immobiliser.
//   clock, reset            : clock / async active-low reset
//   ignition, zone_open     : key state and per-zone door contacts (zone 0 = driver)
//   switch, pedal           : hidden-switch / brake-pedal immobiliser release
//   T_ARM_DELAY, T_ZONE_DELAY, T_ALARM_ON : delays in timer ticks
//   set, siren, fuel_pump   : registered status / actuator drives
//   alarm_zone              : lowest open zone when the last entry started
module alarm_controller_nz
  import alarm_pkg::*;
#(
  parameter int N_ZONES  = 4,
  parameter int TW       = 4,
  parameter int PRESCALE = 1,
  localparam int ZW      = (N_ZONES > 1) ? $clog2(N_ZONES) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ignition,
  input  logic [N_ZONES-1:0]    zone_open,
  input  logic                  switch,
  input  logic                  pedal,
  input  logic [TW-1:0]         T_ARM_DELAY,
  input  logic [N_ZONES*TW-1:0] T_ZONE_DELAY,
  input  logic [TW-1:0]         T_ALARM_ON,
  output logic                  set,
  output logic                  siren,
  output logic                  fuel_pump,
  output logic [ZW-1:0]         alarm_zone
);

  state_t        r_state, w_next;
  logic          r_set, r_siren, r_fuel;
  logic [ZW-1:0] r_zone;

  logic          w_any, w_load, w_latch, w_expired;
  logic [1:0]    w_sel;
  logic [ZW-1:0] w_idx;
  logic [TW-1:0] w_zone_dly, w_value;

  assign w_any = |zone_open;

  // Lowest open zone wins.
  always_comb begin
    w_idx = '0;
    for (int i = N_ZONES - 1; i >= 0; i--)
      if (zone_open[i]) w_idx = ZW'(i);
  end

  assign w_zone_dly = TW'(zone_delay(ZBUS_W'(T_ZONE_DELAY), int'(w_idx), TW));

  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_latch = 1'b0;
    w_sel   = SEL_ARM;
    if (ignition) begin
      w_next = ST_DISARMED;
    end else begin
      case (r_state)
        ST_DISARMED:   w_next = ST_WAIT_OPEN;
        ST_WAIT_OPEN:  if (zone_open[0]) w_next = ST_WAIT_CLOSE;
        ST_WAIT_CLOSE: if (!zone_open[0]) begin
                         w_next = ST_ARMING;
                         w_load = 1'b1;
                         w_sel  = SEL_ARM;
                       end
        // An opening door beats a simultaneous expiry.
        ST_ARMING:     if (w_any)          w_next = ST_WAIT_CLOSE;
                       else if (w_expired) w_next = ST_ARMED;
        ST_ARMED:      if (w_any) begin
                         w_next  = ST_ENTRY;
                         w_load  = 1'b1;
                         w_sel   = SEL_ZONE;
                         w_latch = 1'b1;
                       end
        // Closing the door does not cancel an entry; only ignition does.
        ST_ENTRY:      if (w_expired) w_next = ST_SOUNDING;
        ST_SOUNDING:   if (!w_any) begin
                         w_next = ST_HOLD;
                         w_load = 1'b1;
                         w_sel  = SEL_ALARM;
                       end
        ST_HOLD:       if (w_any)          w_next = ST_SOUNDING;
                       else if (w_expired) w_next = ST_ARMED;
        default:       w_next = ST_DISARMED;
      endcase
    end
  end

  always_comb begin
    case (w_sel)
      SEL_ZONE:  w_value = w_zone_dly;
      SEL_ALARM: w_value = T_ALARM_ON;
      default:   w_value = T_ARM_DELAY;
    endcase
  end

  alarm_timer #(.TW(TW), .PRESCALE(PRESCALE)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (ignition),
    .load    (w_load),
    .value   (w_value),
    .expired (w_expired)
  );

  // Outputs are decoded from the next state so they move with the state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_DISARMED;
      r_set   <= 1'b0;
      r_siren <= 1'b0;
      r_fuel  <= 1'b0;
      r_zone  <= '0;
    end else begin
      r_state <= w_next;
      r_set   <= (w_next inside {ST_ARMED, ST_ENTRY, ST_SOUNDING, ST_HOLD});
      r_siren <= (w_next inside {ST_SOUNDING, ST_HOLD});
      if (w_latch) r_zone <= w_idx;
      // Immobiliser is independent of the alarm FSM.
      if (!ignition)           r_fuel <= 1'b0;
      else if (switch && pedal) r_fuel <= 1'b1;
    end
  end

  assign set        = r_set;
  assign siren      = r_siren;
  assign fuel_pump  = r_fuel;
  assign alarm_zone = r_zone;

endmodule

// File: tb/tb_alarm_controller_nz.sv
module tb_alarm_controller_nz;

  localparam int NZ = 4;
  localparam int TW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          ignition;
  logic [NZ-1:0] zone_open;
  logic          switch, pedal;
  logic [TW-1:0] T_ARM_DELAY, T_ALARM_ON;
  logic [NZ*TW-1:0] T_ZONE_DELAY;
  logic          set, siren, fuel_pump;
  logic [1:0]    alarm_zone;

  alarm_controller_nz #(.N_ZONES(NZ), .TW(TW), .PRESCALE(1)) dut (
    .clock(clock), .reset(reset), .ignition(ignition), .zone_open(zone_open),
    .switch(switch), .pedal(pedal), .T_ARM_DELAY(T_ARM_DELAY),
    .T_ZONE_DELAY(T_ZONE_DELAY), .T_ALARM_ON(T_ALARM_ON),
    .set(set), .siren(siren), .fuel_pump(fuel_pump), .alarm_zone(alarm_zone)
  );

  always #5 clock = ~clock;

  // mask bits: [0] set, [1] siren, [2] fuel_pump, [3] alarm_zone
  typedef struct {
    int         cyc;
    string      name;
    logic [3:0] mask;
    logic       set_e, siren_e, fuel_e;
    logic [1:0] zone_e;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0, n_pass = 0;

  always @(posedge clock) cyc++;

  // Monitor: outputs are sampled on the falling edge, between active edges.
  always @(negedge clock) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        logic ok;
        ok = (q[i].cyc == cyc);
        if (q[i].mask[0] && set       !== q[i].set_e)   ok = 1'b0;
        if (q[i].mask[1] && siren     !== q[i].siren_e) ok = 1'b0;
        if (q[i].mask[2] && fuel_pump !== q[i].fuel_e)  ok = 1'b0;
        if (q[i].mask[3] && alarm_zone !== q[i].zone_e) ok = 1'b0;
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s cyc %0d: set/siren/fuel/zone got %b/%b/%b/%0d want %b/%b/%b/%0d (mask %b)",
                      q[i].name, cyc, set, siren, fuel_pump, alarm_zone,
                      q[i].set_e, q[i].siren_e, q[i].fuel_e, q[i].zone_e, q[i].mask);
        q.delete(i);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic expect_at(input int d, input string name, input logic [3:0] mask,
                           input logic s, input logic sr, input logic f, input logic [1:0] z);
    exp_t e;
    e.cyc = cyc + d; e.name = name; e.mask = mask;
    e.set_e = s; e.siren_e = sr; e.fuel_e = f; e.zone_e = z;
    q.push_back(e);
  endtask

  // Ignition on/off, driver door pulse, then wait out the 5-tick arm delay.
  task automatic arm(input bit chk);
    ignition = 1'b1; tick(1);
    ignition = 1'b0; tick(1);
    zone_open = 4'b0001; tick(1);
    zone_open = 4'b0000;
    if (chk) begin
      expect_at(1, "arm_arming", 4'b0011, 0, 0, 0, 0);
      expect_at(5, "arm_not_yet", 4'b0011, 0, 0, 0, 0);
      expect_at(6, "arm_set", 4'b0011, 1, 0, 0, 0);
    end
    tick(6);
  endtask

  initial begin
    reset = 1'b0; ignition = 1'b0; zone_open = '0; switch = 1'b0; pedal = 1'b0;
    T_ARM_DELAY = 4'd5; T_ALARM_ON = 4'd3;
    T_ZONE_DELAY = {4'd0, 4'd3, 4'd6, 4'd7};   // zone3..zone0
    @(posedge clock); #2;
    expect_at(0, "reset_state", 4'b1111, 0, 0, 0, 0);
    tick(1);
    reset = 1'b1;

    // Arm sequence
    arm(1'b1);

    // Driver entry then alarm, hold 2 cycles, close, hold timer
    zone_open = 4'b0001;
    expect_at(1, "drv_entry", 4'b1011, 1, 0, 0, 0);
    expect_at(7, "drv_pre_siren", 4'b0010, 0, 0, 0, 0);
    expect_at(8, "drv_siren", 4'b1011, 1, 1, 0, 0);
    tick(10);
    zone_open = 4'b0000;
    expect_at(3, "drv_hold", 4'b0011, 1, 1, 0, 0);
    expect_at(4, "drv_rearmed", 4'b0011, 1, 0, 0, 0);
    tick(4);

    // Priority: zones 1 and 3 together; zone 0 joining later must not reload
    zone_open = 4'b1010;
    expect_at(1, "pri_zone", 4'b1011, 1, 0, 0, 1);
    expect_at(6, "pri_pre_siren", 4'b0010, 0, 0, 0, 0);
    expect_at(7, "pri_siren", 4'b1010, 0, 1, 0, 1);
    tick(2);
    zone_open = 4'b1011;
    tick(5);
    zone_open = 4'b0000;
    expect_at(4, "pri_rearmed", 4'b0011, 1, 0, 0, 0);
    tick(4);

    // Zero delay behaves as one tick
    zone_open = 4'b1000;
    expect_at(1, "zero_entry", 4'b1010, 0, 0, 0, 3);
    expect_at(2, "zero_siren", 4'b1010, 0, 1, 0, 3);
    tick(2);
    zone_open = 4'b0000;
    tick(4);

    // Disarm during entry
    zone_open = 4'b0010;
    tick(2);
    ignition = 1'b1;
    expect_at(1, "disarm_entry", 4'b0011, 0, 0, 0, 0);
    for (int d = 2; d <= 8; d++) expect_at(d, "disarm_no_siren", 4'b0011, 0, 0, 0, 0);
    tick(8);
    zone_open = 4'b0000;

    // Reopen on the hold-expiry edge: reopening wins and hold restarts
    arm(1'b0);
    zone_open = 4'b0100;
    expect_at(4, "hold_sounding", 4'b1011, 1, 1, 0, 2);
    tick(4);
    zone_open = 4'b0000;
    tick(3);
    zone_open = 4'b0100;
    expect_at(1, "hold_reopen", 4'b0011, 1, 1, 0, 0);
    expect_at(2, "hold_still_on", 4'b0011, 1, 1, 0, 0);
    tick(1);
    zone_open = 4'b0000;
    expect_at(3, "hold_restart", 4'b0010, 0, 1, 0, 0);
    expect_at(4, "hold_done", 4'b0011, 1, 0, 0, 0);
    tick(4);

    // Re-arm abort: zone opens during ARMING
    ignition = 1'b1; tick(1);
    ignition = 1'b0; tick(1);
    zone_open = 4'b0001; tick(1);
    zone_open = 4'b0000; tick(2);
    zone_open = 4'b0010;
    expect_at(1, "abort_unset", 4'b0001, 0, 0, 0, 0);
    tick(1);
    zone_open = 4'b0000;
    expect_at(3, "abort_old_expiry", 4'b0001, 0, 0, 0, 0);
    expect_at(5, "abort_not_yet", 4'b0001, 0, 0, 0, 0);
    expect_at(6, "abort_set", 4'b0011, 1, 0, 0, 0);
    tick(6);

    // Fuel pump
    ignition = 1'b1; switch = 1'b1; pedal = 1'b1;
    expect_at(1, "fuel_on", 4'b0111, 0, 0, 1, 0);
    tick(1);
    switch = 1'b0; pedal = 1'b0;
    expect_at(1, "fuel_hold1", 4'b0100, 0, 0, 1, 0);
    expect_at(3, "fuel_hold3", 4'b0100, 0, 0, 1, 0);
    tick(3);
    ignition = 1'b0;
    expect_at(1, "fuel_off", 4'b0100, 0, 0, 0, 0);
    tick(1);
    ignition = 1'b1; switch = 1'b1;
    expect_at(1, "fuel_switch_only", 4'b0100, 0, 0, 0, 0);
    expect_at(2, "fuel_switch_only2", 4'b0100, 0, 0, 0, 0);
    tick(2);
    ignition = 1'b0; pedal = 1'b1;
    expect_at(1, "fuel_no_ign", 4'b0100, 0, 0, 0, 0);
    tick(1);
    switch = 1'b0; pedal = 1'b0;

    // Async reset mid-SOUNDING
    arm(1'b0);
    zone_open = 4'b1000;
    expect_at(2, "rst_pre_sounding", 4'b1011, 1, 1, 0, 3);
    tick(3);
    reset = 1'b0;
    expect_at(0, "rst_async", 4'b1111, 0, 0, 0, 0);
    tick(2);
    zone_open = 4'b0000;
    reset = 1'b1;

    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clock);
    if (q.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", q.size());
      n_chk += q.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alarm_controller_nz.md
# alarm_controller_nz

Multi-zone, parametrised successor of the single-car anti-theft alarm controller. It arms after the ignition is switched off and the driver door (zone 0) is opened and closed, then sounds a siren when any of `N_ZONES` monitored doors stays open past its own entry delay. It also gates the fuel pump behind the hidden-switch/brake-pedal sequence. It sits between the debounced vehicle inputs and the siren, status-LED and fuel-relay drivers.

## Interface
- `N_ZONES`, 4, number of door/zone inputs (≥2); zone 0 is the driver door.
- `TW`, 4, width of every delay field and of the timer.
- `PRESCALE`, 1, clock cycles per timer tick (≥1; 1 in simulation).
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ignition`  in  1  ignition key on.
- `zone_open`  in  N_ZONES  1 = door of zone i open.
- `switch`  in  1  hidden switch pressed.
- `pedal`  in  1  brake pedal pressed.
- `T_ARM_DELAY`  in  TW  ticks from driver-door close to armed.
- `T_ZONE_DELAY`  in  N_ZONES*TW  entry delay of zone i, packed in bits [i*TW +: TW].
- `T_ALARM_ON`  in  TW  ticks the siren stays on after all zones close.
- `set`  out  1  armed/alert status indicator.
- `siren`  out  1  siren drive.
- `fuel_pump`  out  1  fuel-pump relay enable.
- `alarm_zone`  out  $clog2(N_ZONES)  zone that caused the last trigger.

## Operation
- States: DISARMED, WAIT_OPEN, WAIT_CLOSE, ARMING, ARMED, ENTRY, SOUNDING, HOLD.
- `ignition`=1 in any state → DISARMED next edge; timer cleared; siren=0.
- DISARMED: ignition=0 → WAIT_OPEN.
- WAIT_OPEN: zone_open[0]=1 → WAIT_CLOSE.
- WAIT_CLOSE: zone_open[0]=0 → ARMING; timer loads T_ARM_DELAY.
- ARMING: any zone_open=1 → WAIT_CLOSE, timer aborted. Timer expiry → ARMED.
- ARMED: any zone_open bit=1 → ENTRY.
  - The lowest open index is latched into `alarm_zone`.
  - The timer loads that zone's delay.
  - Zones opening later during ENTRY do not reload the timer.
- ENTRY: timer expiry → SOUNDING. Closing the door does not cancel the entry; only ignition disarms.
- SOUNDING: stays while any zone is open. All zones closed → HOLD; timer loads T_ALARM_ON.
- HOLD: any zone reopened → SOUNDING. Timer expiry → ARMED.
- Outputs (registered, decoded from next state):
  - `set` = 1 in ARMED, ENTRY, SOUNDING and HOLD.
  - `siren` = 1 in SOUNDING and HOLD.
- Fuel pump:
  - `fuel_pump` clears whenever ignition=0.
  - It sets when ignition=1, switch=1 and pedal=1 in the same cycle, and then holds until ignition=0. This is independent of the alarm FSM.
  - Releasing switch/pedal does not clear it.
- Delay values are sampled only on the load edge; changes mid-count are ignored.

## Timing
- Reset: state=DISARMED, set=0, siren=0, fuel_pump=0, alarm_zone=0, timer=0, prescaler=0.
- Timer semantics:
  - A load of D expires after max(D,1) ticks; one tick = PRESCALE cycles.
  - The prescaler restarts at every load.
  - A delay of 0 therefore behaves as 1.
- With PRESCALE=1, a load on edge k expires on edge k+max(D,1), and the state changes on that edge.
- Input-to-state latency is one edge. Outputs change on the same edge as the state.
- Simultaneous events:
  - Ignition beats every other event.
  - In HOLD, a zone reopening on the expiry edge wins (→ SOUNDING).
  - In ARMING, a zone opening on the expiry edge wins (→ WAIT_CLOSE).
- Reset asserted mid-operation returns everything to reset values immediately; no residual siren.

## Structure
- Package `alarm_pkg` holds:
  - the state enumeration (localparam encoding);
  - the timer-select constants SEL_ARM, SEL_ZONE and SEL_ALARM;
  - a function that extracts zone i's delay from the packed bus.
- Sub-module `alarm_timer` (TW, PRESCALE) has ports `load`, `value` and `expired`, and contains the down-counter plus prescaler.
- The FSM, zone priority encoder and fuel-pump latch live in the top level.

## Test plan
All scenarios use PRESCALE=1, TW=4, N_ZONES=4, T_ARM_DELAY=5, zone delays {7,6,3,0}, T_ALARM_ON=3.
- Arm sequence: reset, ignition 1→0, zone0 pulses for 1 cycle → `set` rises exactly 5 cycles after zone0 falls; siren stays 0.
- Driver entry then alarm: armed, zone0=1 → siren=1 after 7 cycles, alarm_zone=0. Hold door 2 cycles then close → siren falls 3 cycles later; state ARMED, set=1.
- Priority and zero delay:
  - Zones 1 and 3 open together while armed → alarm_zone=1 and siren after 6 cycles.
  - Zone 3 alone → siren 1 cycle after opening.
- Disarm during ENTRY: zone1 opens, ignition=1 at cycle 3 → set=0 and siren=0 next edge; no siren ever.
- Reopen in HOLD and re-arm abort:
  - Zone reopens 2 cycles into HOLD → siren stays 1; the 3-cycle hold restarts after closing.
  - A zone opening during ARMING keeps set=0 until the door closes again and a full 5-cycle delay elapses.
- Fuel pump:
  - ignition=1 with switch=1 and pedal=1 for 1 cycle → fuel_pump=1 next edge and it stays 1 after release.
  - ignition=0 → fuel_pump=0.
  - switch alone → stays 0.
  - Async reset mid-SOUNDING → all outputs 0 without a clock edge.
